riscv_hazard_ctrl: RTL and testbench

//  Central pipeline-control unit for the 5-stage RISC-V core: stall/flush generation, EX-operand forwarding select,

---
 rtl/riscv_hazard_ctrl_pkg.sv | 17 +
 rtl/riscv_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/riscv_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package riscv_hazard_ctrl_pkg;

  localparam int unsigned FWD_W = 2;

  // EX operand source selects
  localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'd1;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'd2;

  // RUN: normal flow; IWAIT_REDIR: redirect pending behind an I-cache miss
  typedef enum logic {
    RUN         = 1'b0,
    IWAIT_REDIR = 1'b1
  } hz_state_e;

endpackage

// File: rtl/riscv_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module riscv_hazard_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment unless already saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline control: stalls, flushes, PC redirect sequencing, EX forwarding, perf counters.
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic [XLEN-1:0]   id_target,
  input  logic [RIDX_W-1:0] ex_rs1,
  input  logic [RIDX_W-1:0] ex_rs2,
  input  logic [RIDX_W-1:0] ex_rd,
  input  logic              ex_regwr,
  input  logic              ex_memrd,
  input  logic              ex_jump,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic              mem_regwr,
  input  logic              mem_memrd,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic              wb_regwr,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              mem_wb_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pc_load,
  output logic [XLEN-1:0]   pc_target,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  cnt_dstall,
  output logic [CNT_W-1:0]  cnt_istall,
  output logic [CNT_W-1:0]  cnt_hazard,
  output logic [CNT_W-1:0]  cnt_flush
);

  hz_state_e         state, state_nxt;
  logic [XLEN-1:0]   redir_tgt;
  logic              latch_en;
  logic              inc_dstall, inc_istall, inc_hazard, inc_flush;
  logic              ex_hit, mem_hit, load_use, br_ilock, interlock, redirect;
  logic [XLEN-1:0]   sel_tgt;

  // Forward select for one EX source: MEM/EX result beats WB, x0 never forwards
  function automatic logic [1:0] fwd_pick(
    input logic [RIDX_W-1:0] rs,
    input logic [RIDX_W-1:0] m_rd,
    input logic              m_wr,
    input logic              m_ld,
    input logic [RIDX_W-1:0] w_rd,
    input logic              w_wr
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (m_wr && !m_ld && (m_rd == rs))  sel = FWD_MEM;
      else if (w_wr && (w_rd == rs))      sel = FWD_WB;
    end
    return sel;
  endfunction

  // ID source-register matches against EX and MEM destinations (x0 excluded)
  assign ex_hit  = (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
  assign mem_hit = (mem_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == mem_rd)) || (id_rs2_used && (id_rs2 == mem_rd)));

  assign load_use  = ex_memrd && ex_hit;
  assign br_ilock  = id_is_branch && ((ex_regwr && ex_hit) || (mem_memrd && mem_hit));
  assign interlock = load_use || br_ilock;

  // A taken ID branch is only trusted when its operands are not interlocked; EX jump is older and wins
  assign redirect = ex_jump || (id_branch_taken && !interlock);
  assign sel_tgt  = ex_jump ? ex_target : id_target;

  // Forwarding is independent of stall state
  assign fwd_a_sel = rst ? FWD_RF : fwd_pick(ex_rs1, mem_rd, mem_regwr, mem_memrd, wb_rd, wb_regwr);
  assign fwd_b_sel = rst ? FWD_RF : fwd_pick(ex_rs2, mem_rd, mem_regwr, mem_memrd, wb_rd, wb_regwr);

  // State and pending-redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      redir_tgt <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) redir_tgt <= sel_tgt;
    end
  end

  // Next state and control outputs, priority dcache > redirect > interlock > icache > advance
  always_comb begin
    state_nxt    = state;
    latch_en     = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pc_load      = 1'b0;
    pc_target    = '0;
    inc_dstall   = 1'b0;
    inc_istall   = 1'b0;
    inc_hazard   = 1'b0;
    inc_flush    = 1'b0;

    if (rst) begin
      state_nxt = RUN;
    end else if (dcache_stall) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
      inc_dstall   = 1'b1;
    end else if (state == IWAIT_REDIR) begin
      if_id_flush = 1'b1;
      if (icache_stall) begin
        pc_stall = 1'b1;
      end else begin
        pc_load   = 1'b1;
        pc_target = redir_tgt;
        state_nxt = RUN;
      end
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = ex_jump;
      inc_flush   = 1'b1;
      if (icache_stall) begin
        pc_stall  = 1'b1;
        latch_en  = 1'b1;
        state_nxt = IWAIT_REDIR;
      end else begin
        pc_load   = 1'b1;
        pc_target = sel_tgt;
      end
    end else begin
      inc_istall = icache_stall;
      if (interlock) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        inc_hazard  = 1'b1;
      end else if (icache_stall) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  // ID cannot hold a live redirect while a redirect is pending: ID is being flushed
  a_no_redir_in_wait: assert property (@(posedge clk) disable iff (rst)
    (state == IWAIT_REDIR && !dcache_stall) |-> !(ex_jump || id_branch_taken));

  riscv_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_dstall (
    .clk(clk), .rst(rst), .inc(inc_dstall), .count(cnt_dstall));
  riscv_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_istall (
    .clk(clk), .rst(rst), .inc(inc_istall), .count(cnt_istall));
  riscv_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_hazard (
    .clk(clk), .rst(rst), .inc(inc_hazard), .count(cnt_hazard));
  riscv_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk(clk), .rst(rst), .inc(inc_flush), .count(cnt_flush));

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Scoreboard bench for riscv_hazard_ctrl (CNT_W=4 so saturation is reachable).
module tb_riscv_hazard_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              icache_stall, dcache_stall;
  logic [RIDX_W-1:0] id_rs1, id_rs2;
  logic              id_rs1_used, id_rs2_used, id_is_branch, id_branch_taken;
  logic [XLEN-1:0]   id_target;
  logic [RIDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_regwr, ex_memrd, ex_jump;
  logic [XLEN-1:0]   ex_target;
  logic [RIDX_W-1:0] mem_rd;
  logic              mem_regwr, mem_memrd;
  logic [RIDX_W-1:0] wb_rd;
  logic              wb_regwr;
  logic              pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic              if_id_flush, id_ex_flush, pc_load;
  logic [XLEN-1:0]   pc_target;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  cnt_dstall, cnt_istall, cnt_hazard, cnt_flush;

  // Expected control word: {pc_stall,if_id_stall,id_ex_stall,ex_mem_stall,mem_wb_stall,if_id_flush,id_ex_flush,pc_load}
  typedef struct {
    string       tag;
    logic [7:0]  ctl;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_ILOCK = 8'b1100_0010;
  localparam logic [7:0] C_DSTL  = 8'b1111_1000;
  localparam logic [7:0] C_ISTL  = 8'b1000_0100;
  localparam logic [7:0] C_JUMP  = 8'b0000_0111;
  localparam logic [7:0] C_BRNCH = 8'b0000_0101;

  riscv_hazard_ctrl #(.XLEN(XLEN), .RIDX_W(RIDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_target(id_target),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .ex_jump(ex_jump), .ex_target(ex_target),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_load(pc_load), .pc_target(pc_target),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .cnt_dstall(cnt_dstall), .cnt_istall(cnt_istall), .cnt_hazard(cnt_hazard), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    icache_stall = 0; dcache_stall = 0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_is_branch = 0; id_branch_taken = 0; id_target = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwr = 0; ex_memrd = 0;
    ex_jump = 0; ex_target = '0;
    mem_rd = '0; mem_regwr = 0; mem_memrd = 0;
    wb_rd = '0; wb_regwr = 0;
  endtask

  // Push expectation for the inputs just driven, let logic settle, pop and compare, advance one cycle
  task automatic cyc(input string tag, input logic [7:0] ctl, input logic [31:0] tgt);
    exp_t e;
    sb_q.push_back('{tag: tag, ctl: ctl, tgt: tgt});
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".ctl"}, 64'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                                if_id_flush, id_ex_flush, pc_load}), 64'(e.ctl));
    if (e.ctl[0]) check({e.tag, ".tgt"}, 64'(pc_target), 64'(e.tgt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr_in();
  endtask

  task automatic set_load_use();
    ex_memrd = 1; ex_regwr = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    icache_stall = 1; dcache_stall = 1; ex_jump = 1; ex_target = 32'h100;
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_regwr = 1;
    @(negedge clk);
    cyc("reset", C_IDLE, 32'h0);
    check("reset.fwd_a", 64'(fwd_a_sel), 64'd0);
    check("reset.cnt", 64'({cnt_dstall, cnt_istall, cnt_hazard, cnt_flush}), 64'd0);
    rst = 1'b0;
    clr_in();

    // Load-use and its non-matching boundaries
    set_load_use();
    cyc("lu", C_ILOCK, 0);
    clr_in();
    cyc("lu.after", C_IDLE, 0);
    check("lu.cnt_hazard", 64'(cnt_hazard), 64'd1);
    ex_memrd = 1; ex_regwr = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
    cyc("lu.x0", C_IDLE, 0);
    set_load_use(); id_rs1_used = 0;
    cyc("lu.unused", C_IDLE, 0);
    set_load_use(); id_rs1 = 5'd6; id_rs2 = 5'd5; id_rs2_used = 1;
    cyc("lu.rs2", C_ILOCK, 0);
    clr_in();

    // EX jump beats ID branch
    ex_jump = 1; ex_target = 32'h100; id_branch_taken = 1; id_target = 32'h200;
    cyc("jump", C_JUMP, 32'h100);
    clr_in();
    cyc("jump.after", C_IDLE, 0);
    check("jump.cnt_flush", 64'(cnt_flush), 64'd1);

    // Taken branch behind an I-cache miss
    do_reset();
    id_branch_taken = 1; id_target = 32'h40; icache_stall = 1;
    cyc("iw.enter", C_ISTL, 0);
    id_branch_taken = 0; id_target = 32'h999;
    cyc("iw.wait1", C_ISTL, 0);
    cyc("iw.wait2", C_ISTL, 0);
    icache_stall = 0;
    cyc("iw.load", C_BRNCH, 32'h40);
    cyc("iw.run", C_IDLE, 0);
    check("iw.cnt_flush", 64'(cnt_flush), 64'd1);
    check("iw.cnt_istall", 64'(cnt_istall), 64'd0);

    // D-cache stall freezes a pending load-use
    do_reset();
    set_load_use(); dcache_stall = 1;
    for (int i = 0; i < 5; i++) cyc("dstall", C_DSTL, 0);
    check("dstall.cnt_dstall", 64'(cnt_dstall), 64'd5);
    check("dstall.cnt_hazard", 64'(cnt_hazard), 64'd0);
    dcache_stall = 0;
    cyc("dstall.release", C_ILOCK, 0);
    check("dstall.cnt_hazard2", 64'(cnt_hazard), 64'd1);
    clr_in();

    // Branch interlocks suppress the taken branch until operands are ready
    id_is_branch = 1; id_branch_taken = 1; id_target = 32'h80; id_rs2 = 5'd9; id_rs2_used = 1;
    ex_regwr = 1; ex_rd = 5'd9;
    cyc("br.ex", C_ILOCK, 0);
    ex_regwr = 0; ex_rd = '0; mem_memrd = 1; mem_regwr = 1; mem_rd = 5'd9;
    cyc("br.memld", C_ILOCK, 0);
    mem_memrd = 0;
    cyc("br.go", C_BRNCH, 32'h80);
    check("br.cnt_hazard", 64'(cnt_hazard), 64'd3);
    clr_in();

    // Interlock wins over I-cache bubble, I-cache cycle still counted
    set_load_use(); icache_stall = 1;
    cyc("lu.istall", C_ILOCK, 0);
    check("lu.istall.cnt", 64'(cnt_istall), 64'd1);
    clr_in();

    // Forwarding selects
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_regwr = 1; wb_rd = 5'd7; wb_regwr = 1; #1;
    check("fwd.mem", 64'(fwd_a_sel), 64'd1);
    mem_rd = 5'd0; #1;
    check("fwd.wb", 64'(fwd_a_sel), 64'd2);
    ex_rs1 = 5'd0; #1;
    check("fwd.x0", 64'(fwd_a_sel), 64'd0);
    ex_rs2 = 5'd4; mem_rd = 5'd4; mem_memrd = 1; wb_rd = 5'd4; dcache_stall = 1; #1;
    check("fwd.b_memld", 64'(fwd_b_sel), 64'd2);
    mem_memrd = 0; #1;
    check("fwd.b_mem", 64'(fwd_b_sel), 64'd1);
    @(negedge clk);

    // Counter saturation, then reset out of a pending redirect
    do_reset();
    icache_stall = 1;
    for (int i = 0; i < 20; i++) cyc("istall", C_ISTL, 0);
    check("istall.sat", 64'(cnt_istall), 64'd15);
    ex_jump = 1; ex_target = 32'h300;
    cyc("rst.enter", 8'b1000_0110, 0);
    ex_jump = 0;
    cyc("rst.wait", C_ISTL, 0);
    rst = 1'b1;
    cyc("rst.mid", C_IDLE, 0);
    rst = 1'b0; clr_in();
    cyc("rst.run", C_IDLE, 0);
    check("rst.cnt", 64'({cnt_dstall, cnt_istall, cnt_hazard, cnt_flush}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
